// File: rtl/fetch_mem_ctrl.sv
// ---------------------------------------------------------------------------------------------
// fetch_mem_ctrl
//
// Sequences the single byte-wide RAM port between instruction fetch and the MEM-stage data
// port. An icache miss reads four bytes, assembles a little-endian word, returns it to fetch
// and writes it into the icache. Data loads and stores of 1, 2 or 4 bytes are serialised
// byte-by-byte over the same RAM port. Icache hits are returned combinationally, even while
// a data transaction is using the RAM.
//
// Optional feature (define NEXT_LINE_PREFETCH_EN):
//   After a fetch refill completes and nothing else is requested, the next sequential word
//   (addr+4) is refilled into the icache. A data request, a flush or a miss to another address
//   aborts it; a miss to addr+4 merges with it and receives if_done_o at completion.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   if_req_i/if_addr_i  fetch request (level) and address
//   if_flush_i          abort an in-flight fetch refill
//   if_done_o/if_inst_o fetch result pulse and instruction
//   ic_hit_i/ic_inst_i  icache lookup result for if_addr_i
//   ic_we_o/ic_waddr_o/ic_winst_o  icache refill write
//   mem_req_i/mem_we_i/mem_len_i/mem_addr_i/mem_wdata_i  data request (level)
//   mem_done_o/mem_rdata_o  data completion pulse and zero-extended load data
//   ram_addr_o/ram_dout_o/ram_wr_o/ram_din_i  byte-wide RAM port (read data one cycle late)
// ---------------------------------------------------------------------------------------------
module fetch_mem_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_done_o,
    output logic [31:0]       if_inst_o,

    input  logic              ic_hit_i,
    input  logic [31:0]       ic_inst_i,
    output logic              ic_we_o,
    output logic [ADDR_W-1:0] ic_waddr_o,
    output logic [31:0]       ic_winst_o,

    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_done_o,
    output logic [31:0]       mem_rdata_o,

    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_dout_o,
    output logic              ram_wr_o,
    input  logic [7:0]        ram_din_i
);

    typedef enum logic [2:0] {
        StIdle,
        StIfRd,
        StDRd,
        StDWr,
        StDone
`ifdef NEXT_LINE_PREFETCH_EN
        , StIfPf
`endif
    } state_t;

    state_t            state;
    logic [2:0]        cnt;        // cycle index within the current read/write state
    logic [2:0]        nbytes;     // transfer length in bytes (1, 2 or 4)
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       word;       // bytes captured so far, upper bytes stay zero
    logic              is_fetch;

    // Registered outputs
    logic [ADDR_W-1:0] ram_addr_r;
    logic [7:0]        ram_dout_r;
    logic              ram_wr_r;
    logic              fetch_done_r;
    logic [31:0]       fetch_inst_r;
    logic              ic_we_r;
    logic [ADDR_W-1:0] ic_waddr_r;
    logic [31:0]       ic_winst_r;
    logic              mem_done_r;
    logic [31:0]       mem_rdata_r;

    logic              fetch_miss;
    logic              hit_serve;
    logic              fetch_done_ok;
    logic [2:0]        cnt_nx;
    logic [1:0]        cap_idx;
    logic [31:0]       rd_word;
    logic              rd_abort;
    logic              pf_abort;

`ifdef NEXT_LINE_PREFETCH_EN
    logic              pf_pending;  // a fetch refill just finished; prefetch its successor
    logic              pf_mode;     // current refill is a prefetch
    logic              pf_merged;   // fetch missed on the prefetch address
    logic              pf_hit_now;
`endif

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        unique case (len)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;  // 10 is illegal and handled as a word
        endcase
    endfunction

    assign fetch_miss = if_req_i && !ic_hit_i;
    assign cnt_nx     = cnt + 3'd1;

    // Byte captured this cycle belongs to the address driven on the previous cycle.
    always_comb begin
        cap_idx = cnt[1:0] - 2'd1;
        rd_word = word;
        if (cnt != 3'd0) begin
            rd_word[{cap_idx, 3'b000} +: 8] = ram_din_i;
        end
    end

`ifdef NEXT_LINE_PREFETCH_EN
    assign pf_hit_now = fetch_miss && (if_addr_i == addr);
    assign pf_abort   = (state == StIfPf) &&
                        (mem_req_i || if_flush_i || (fetch_miss && (if_addr_i != addr)));
`else
    assign pf_abort   = 1'b0;
`endif

    assign rd_abort = ((state == StIfRd) && if_flush_i) || pf_abort;

    // Hit path bypasses the FSM; suppressed only while a demand refill owns fetch.
    assign hit_serve     = !rst && if_req_i && ic_hit_i && (state != StIfRd);
    // A flush in the completion cycle still cancels the refill result.
    assign fetch_done_ok = fetch_done_r && !if_flush_i;

    assign if_done_o   = fetch_done_ok || hit_serve;
    assign if_inst_o   = fetch_done_ok ? fetch_inst_r : (hit_serve ? ic_inst_i : 32'h0);
    assign ic_we_o     = ic_we_r && !if_flush_i;
    assign ic_waddr_o  = ic_waddr_r;
    assign ic_winst_o  = ic_winst_r;
    assign mem_done_o  = mem_done_r;
    assign mem_rdata_o = mem_rdata_r;
    assign ram_addr_o  = ram_addr_r;
    assign ram_dout_o  = ram_dout_r;
    assign ram_wr_o    = ram_wr_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            cnt          <= '0;
            nbytes       <= '0;
            addr         <= '0;
            wdata        <= '0;
            word         <= '0;
            is_fetch     <= 1'b0;
            ram_addr_r   <= '0;
            ram_dout_r   <= '0;
            ram_wr_r     <= 1'b0;
            fetch_done_r <= 1'b0;
            fetch_inst_r <= '0;
            ic_we_r      <= 1'b0;
            ic_waddr_r   <= '0;
            ic_winst_r   <= '0;
            mem_done_r   <= 1'b0;
            mem_rdata_r  <= '0;
`ifdef NEXT_LINE_PREFETCH_EN
            pf_pending   <= 1'b0;
            pf_mode      <= 1'b0;
            pf_merged    <= 1'b0;
`endif
        end else begin
            fetch_done_r <= 1'b0;
            ic_we_r      <= 1'b0;
            mem_done_r   <= 1'b0;

            unique case (state)
                StIdle: begin
                    cnt  <= '0;
                    word <= '0;
`ifdef NEXT_LINE_PREFETCH_EN
                    pf_pending <= 1'b0;
                    pf_mode    <= 1'b0;
                    pf_merged  <= 1'b0;
`endif
                    if (mem_req_i) begin
                        state      <= mem_we_i ? StDWr : StDRd;
                        addr       <= mem_addr_i;
                        nbytes     <= len_bytes(mem_len_i);
                        wdata      <= mem_wdata_i;
                        is_fetch   <= 1'b0;
                        ram_addr_r <= mem_addr_i;
                        ram_wr_r   <= mem_we_i;
                        ram_dout_r <= mem_we_i ? mem_wdata_i[7:0] : 8'h00;
                    end else if (fetch_miss) begin
                        state      <= StIfRd;
                        addr       <= if_addr_i;
                        nbytes     <= 3'd4;
                        is_fetch   <= 1'b1;
                        ram_addr_r <= if_addr_i;
                    end
`ifdef NEXT_LINE_PREFETCH_EN
                    else if (pf_pending) begin
                        state      <= StIfPf;
                        addr       <= addr + ADDR_W'(4);
                        nbytes     <= 3'd4;
                        is_fetch   <= 1'b1;
                        pf_mode    <= 1'b1;
                        ram_addr_r <= addr + ADDR_W'(4);
                    end
`endif
                end

                StIfRd, StDRd
`ifdef NEXT_LINE_PREFETCH_EN
                , StIfPf
`endif
                : begin
`ifdef NEXT_LINE_PREFETCH_EN
                    if (pf_hit_now) begin
                        pf_merged <= 1'b1;
                    end
`endif
                    if (rd_abort) begin
                        state      <= StIdle;
                        cnt        <= '0;
                        ram_addr_r <= '0;
                    end else if (cnt == nbytes) begin
                        state      <= StDone;
                        ram_addr_r <= '0;
                        if (is_fetch) begin
`ifdef NEXT_LINE_PREFETCH_EN
                            fetch_done_r <= !pf_mode || pf_merged || pf_hit_now;
                            pf_pending   <= !pf_mode;
`else
                            fetch_done_r <= 1'b1;
`endif
                            fetch_inst_r <= rd_word;
                            ic_we_r      <= 1'b1;
                            ic_waddr_r   <= addr;
                            ic_winst_r   <= rd_word;
                        end else begin
                            mem_done_r  <= 1'b1;
                            mem_rdata_r <= rd_word;
                        end
                    end else begin
                        word <= rd_word;
                        cnt  <= cnt_nx;
                        if (cnt_nx < nbytes) begin
                            ram_addr_r <= addr + ADDR_W'(cnt_nx);
                        end
                    end
                end

                StDWr: begin
                    if (cnt_nx == nbytes) begin
                        state      <= StDone;
                        ram_wr_r   <= 1'b0;
                        ram_addr_r <= '0;
                        ram_dout_r <= '0;
                        mem_done_r <= 1'b1;
                    end else begin
                        cnt        <= cnt_nx;
                        ram_addr_r <= addr + ADDR_W'(cnt_nx);
                        ram_dout_r <= wdata[{cnt_nx[1:0], 3'b000} +: 8];
                    end
                end

                StDone: begin
                    state <= StIdle;
`ifdef NEXT_LINE_PREFETCH_EN
                    // A cancelled refill must not seed a prefetch.
                    if (if_flush_i) begin
                        pf_pending <= 1'b0;
                    end
`endif
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_mem_ctrl.sv
module tb_fetch_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_done;
    logic [31:0] if_inst;
    logic        ic_hit;
    logic [31:0] ic_inst;
    logic        ic_we;
    logic [31:0] ic_waddr;
    logic [31:0] ic_winst;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [31:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic [7:0]  ram_din;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_mem_ctrl #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_flush_i (if_flush),
        .if_done_o  (if_done),
        .if_inst_o  (if_inst),
        .ic_hit_i   (ic_hit),
        .ic_inst_i  (ic_inst),
        .ic_we_o    (ic_we),
        .ic_waddr_o (ic_waddr),
        .ic_winst_o (ic_winst),
        .mem_req_i  (mem_req),
        .mem_we_i   (mem_we),
        .mem_len_i  (mem_len),
        .mem_addr_i (mem_addr),
        .mem_wdata_i(mem_wdata),
        .mem_done_o (mem_done),
        .mem_rdata_o(mem_rdata),
        .ram_addr_o (ram_addr),
        .ram_dout_o (ram_dout),
        .ram_wr_o   (ram_wr),
        .ram_din_i  (ram_din)
    );

    // Byte RAM: 64 KiB window, preset contents come from init_byte until written.
    bit [7:0]    ram     [0:65535];
    bit          written [0:65535];
    int unsigned wr_count = 0;

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        case (a)
            16'h0100: return 8'h13;
            16'h0101: return 8'h05;
            16'h0200: return 8'h11;
            16'h0201: return 8'h22;
            16'h0202: return 8'h33;
            16'h0203: return 8'h44;
            16'h2000: return 8'h34;
            16'h2001: return 8'h12;
            16'hFFFE: return 8'hAA;
            16'hFFFF: return 8'hBB;
            16'h0000: return 8'hCC;
            16'h0001: return 8'hDD;
            default:  return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] rd_byte(input logic [15:0] a);
        return written[a] ? ram[a] : init_byte(a);
    endfunction

    always @(posedge clk) begin
        ram_din <= rd_byte(ram_addr[15:0]);
        if (ram_wr) begin
            ram[ram_addr[15:0]]     <= ram_dout;
            written[ram_addr[15:0]] <= 1'b1;
            wr_count                <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int unsigned wr_before;
    logic        saw;

    initial begin
        rst = 1'b1; if_req = 0; if_addr = 0; if_flush = 0; ic_hit = 0; ic_inst = 0;
        mem_req = 0; mem_we = 0; mem_len = 0; mem_addr = 0; mem_wdata = 0;
        step();
        step();
        chk("rst_if_done",   {31'b0, if_done},  32'h0);
        chk("rst_if_inst",   if_inst,           32'h0);
        chk("rst_mem_done",  {31'b0, mem_done}, 32'h0);
        chk("rst_mem_rdata", mem_rdata,         32'h0);
        chk("rst_ram_addr",  ram_addr,          32'h0);
        chk("rst_ram_wr",    {31'b0, ram_wr},   32'h0);
        chk("rst_ic_we",     {31'b0, ic_we},    32'h0);
        rst = 1'b0;

        // Fetch miss at 0x100: 13 05 00 00 -> 0x00000513 in cycle 5
        if_req = 1; if_addr = 32'h100; ic_hit = 0;
        step();
        chk("if_c0_addr", ram_addr, 32'h100);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k <= 3) chk("if_addr_k", ram_addr, 32'h100 + k);
            chk("if_early_done", {31'b0, if_done}, 32'h0);
        end
        step();
        chk("if_done",   {31'b0, if_done}, 32'h1);
        chk("if_inst",   if_inst,          32'h00000513);
        chk("if_ic_we",  {31'b0, ic_we},   32'h1);
        chk("if_waddr",  ic_waddr,         32'h100);
        chk("if_winst",  ic_winst,         32'h00000513);
        if_req = 0;
        step();
        chk("if_done_pulse", {31'b0, if_done}, 32'h0);
        chk("if_we_pulse",   {31'b0, ic_we},   32'h0);

        // Store word to 0x3000 with an icache hit served during the write
        wr_before = wr_count;
        mem_req = 1; mem_we = 1; mem_len = 2'b11; mem_addr = 32'h3000; mem_wdata = 32'hA1B2C3D4;
        step();
        chk("st_c0_wr",   {31'b0, ram_wr}, 32'h1);
        chk("st_c0_addr", ram_addr,        32'h3000);
        chk("st_c0_dout", {24'b0, ram_dout}, 32'hD4);
        if_req = 1; if_addr = 32'h500; ic_hit = 1; ic_inst = 32'hDEADBEEF;
        #1;
        chk("hit_done", {31'b0, if_done}, 32'h1);
        chk("hit_inst", if_inst,          32'hDEADBEEF);
        chk("hit_dout", {24'b0, ram_dout}, 32'hD4);
        step();
        if_req = 0; ic_hit = 0; ic_inst = 0;
        chk("st_c1_addr", ram_addr,          32'h3001);
        chk("st_c1_dout", {24'b0, ram_dout}, 32'hC3);
        step();
        chk("st_c2_dout", {24'b0, ram_dout}, 32'hB2);
        step();
        chk("st_c3_addr", ram_addr,          32'h3003);
        chk("st_c3_dout", {24'b0, ram_dout}, 32'hA1);
        chk("st_c3_done", {31'b0, mem_done}, 32'h0);
        step();
        chk("st_done",    {31'b0, mem_done}, 32'h1);
        chk("st_done_wr", {31'b0, ram_wr},   32'h0);
        mem_req = 0; mem_we = 0;
        step();
        chk("st_done_pulse", {31'b0, mem_done}, 32'h0);
        chk("st_wr_count", wr_count - wr_before, 32'd4);
        chk("st_ram", {rd_byte(16'h3003), rd_byte(16'h3002), rd_byte(16'h3001),
                       rd_byte(16'h3000)}, 32'hA1B2C3D4);

        // Simultaneous halfword load and fetch miss: data first
        mem_req = 1; mem_we = 0; mem_len = 2'b01; mem_addr = 32'h2000;
        if_req = 1; if_addr = 32'h100; ic_hit = 0;
        step();
        chk("ld_c0_addr", ram_addr,        32'h2000);
        chk("ld_c0_wr",   {31'b0, ram_wr}, 32'h0);
        step();
        chk("ld_c1_addr", ram_addr, 32'h2001);
        step();
        chk("ld_c2_done", {31'b0, mem_done}, 32'h0);
        step();
        chk("ld_done",   {31'b0, mem_done}, 32'h1);
        chk("ld_rdata",  mem_rdata,         32'h00001234);
        chk("ld_if_idle", {31'b0, if_done}, 32'h0);
        mem_req = 0;
        step();
        step();
        chk("ld_then_if_addr", ram_addr, 32'h100);
        for (int k = 0; k < 5; k++) step();
        chk("ld_then_if_done", {31'b0, if_done}, 32'h1);
        chk("ld_then_if_inst", if_inst,          32'h00000513);
        if_req = 0;
        step();

        // Flush at cycle 2 of a refill
        if_req = 1; if_addr = 32'h200; ic_hit = 0;
        step();
        step();
        step();
        chk("fl_c2_addr", ram_addr, 32'h202);
        if_flush = 1; if_req = 0;
        step();
        if_flush = 0;
        chk("fl_c3_addr", ram_addr, 32'h0);
        saw = if_done | ic_we;
        // Byte load issued from the cycle-3 IDLE state
        mem_req = 1; mem_we = 0; mem_len = 2'b00; mem_addr = 32'h2001;
        step();
        saw = saw | if_done | ic_we;
        chk("fl_ld_c0_addr", ram_addr, 32'h2001);
        step();
        saw = saw | if_done | ic_we;
        step();
        saw = saw | if_done | ic_we;
        chk("fl_no_done", {31'b0, saw},      32'h0);
        chk("b_done",     {31'b0, mem_done}, 32'h1);
        chk("b_rdata",    mem_rdata,         32'h00000012);
        mem_req = 0;
        step();

        // Length 10 acts as a word; address wraps past 0xFFFFFFFF
        mem_req = 1; mem_we = 0; mem_len = 2'b10; mem_addr = 32'hFFFFFFFE;
        step();
        chk("wr_c0_addr", ram_addr, 32'hFFFFFFFE);
        step();
        chk("wr_c1_addr", ram_addr, 32'hFFFFFFFF);
        step();
        chk("wr_c2_addr", ram_addr, 32'h00000000);
        step();
        chk("wr_c3_addr", ram_addr, 32'h00000001);
        step();
        chk("wr_c4_done", {31'b0, mem_done}, 32'h0);
        step();
        chk("wr_done",  {31'b0, mem_done}, 32'h1);
        chk("wr_rdata", mem_rdata,         32'hDDCCBBAA);
        mem_req = 0;
        step();

        // Reset during cycle 2 of a word store
        mem_req = 1; mem_we = 1; mem_len = 2'b11; mem_addr = 32'h4000; mem_wdata = 32'h55667788;
        step();
        step();
        step();
        chk("rs_c2_addr", ram_addr, 32'h4002);
        rst = 1; mem_req = 0; mem_we = 0;
        step();
        chk("rs_ram_addr", ram_addr,          32'h0);
        chk("rs_ram_wr",   {31'b0, ram_wr},   32'h0);
        chk("rs_ram_dout", {24'b0, ram_dout}, 32'h0);
        chk("rs_mem_done", {31'b0, mem_done}, 32'h0);
        chk("rs_rdata",    mem_rdata,         32'h0);
        chk("rs_if_done",  {31'b0, if_done},  32'h0);
        chk("rs_ic_we",    {31'b0, ic_we},    32'h0);
        rst = 0;
        saw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            saw = saw | mem_done | ram_wr;
        end
        chk("rs_no_done", {31'b0, saw}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_mem_ctrl.md
Name: fetch_mem_ctrl

Overview:
Sequences the single byte-wide RAM port between instruction fetch and the MEM-stage data port.
On an icache miss it reads 4 bytes, assembles a little-endian word, returns it to fetch and writes it into the icache.
Data loads and stores of 1, 2 or 4 bytes are serialised byte-by-byte over the same RAM port.
The icache read port is driven by fetch directly; this block only consumes the resulting hit/data.

Parameters:
ADDR_W, 32, width of all byte addresses

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
if_req_i  in  1  fetch request, level, held until if_done_o
if_addr_i  in  ADDR_W  fetch address, stable while if_req_i
if_flush_i  in  1  abort in-flight fetch refill (branch redirect)
if_done_o  out  1  fetch result valid, one-cycle pulse
if_inst_o  out  32  fetched instruction
ic_hit_i  in  1  icache hit for if_addr_i
ic_inst_i  in  32  icache data for if_addr_i
ic_we_o  out  1  icache write strobe
ic_waddr_o  out  ADDR_W  icache write address
ic_winst_o  out  32  icache write data
mem_req_i  in  1  data request, level, held until mem_done_o
mem_we_i  in  1  1 = store, 0 = load
mem_len_i  in  2  00 = 1 byte, 01 = 2 bytes, 11 = 4 bytes (10 = illegal)
mem_addr_i  in  ADDR_W  data byte address
mem_wdata_i  in  32  store data, little-endian
mem_done_o  out  1  data access complete, one-cycle pulse
mem_rdata_o  out  32  load data, zero-extended
ram_addr_o  out  ADDR_W  RAM byte address
ram_dout_o  out  8  RAM write byte
ram_wr_o  out  1  RAM write enable
ram_din_i  in  8  RAM read byte, valid the cycle after its address (wr=0)

Behaviour:
- Reset: FSM enters IDLE, byte counter 0. All outputs are 0, including ram_addr_o.
- States: IDLE, IF_RD, D_RD, D_WR, DONE.
- Hit path: when the FSM is not in IF_RD and if_req_i && ic_hit_i, drive if_done_o=1 and if_inst_o=ic_inst_i combinationally in the same cycle. The hit is served even while a data transaction is in progress.
- IDLE arbitration:
  - mem_req_i has priority over a fetch miss, giving D_RD or D_WR.
  - Otherwise a fetch miss (if_req_i && !ic_hit_i) gives IF_RD.
  - A request arriving in the same cycle is latched with its address, length and data.
- IF_RD:
  - ram_addr_o = addr+k for k = 0..3 on cycles 0..3; byte k is captured from ram_din_i on cycle k+1 into bits [8k+7:8k].
  - Cycle 5 (DONE): if_done_o=1, if_inst_o=word, ic_we_o=1, ic_waddr_o=addr, ic_winst_o=word.
  - Total 5 cycles, then IDLE.
- D_RD: N bytes are read the same way. DONE falls on cycle N+1 with mem_done_o=1 and mem_rdata_o zero-extended; upper bytes are 0.
- D_WR: ram_wr_o=1 with ram_dout_o = wdata byte k at addr+k for k = 0..N-1. DONE falls on cycle N with mem_done_o=1. ram_wr_o is 0 in DONE.
- Done outputs are single-cycle pulses. Requesters drop req at the edge where done is seen, so IDLE does not re-trigger.
- if_flush_i in IF_RD or its DONE cycle: abort, no ic_we_o, no if_done_o, go to IDLE next cycle. if_flush_i has no effect on data states.
- Address arithmetic wraps modulo 2^ADDR_W.
- mem_len_i = 10 is treated as 4 bytes.
- rst mid-transaction: abandon immediately with no done pulse and no cache write. A partial store may remain in RAM.

Optional Feature:
NEXT_LINE_PREFETCH_EN
- With the macro: after an IF_RD completes, if IDLE sees no request, state IF_PF refills addr+4 exactly like IF_RD but without if_done_o.
  - mem_req_i, if_flush_i, or a miss to a different address aborts IF_PF within 1 cycle with no cache write; the new request then starts.
  - A miss to addr+4 merges: the prefetch continues and pulses if_done_o at completion.
- Without the macro: IF_PF does not exist.

Test Plan:
- Fetch miss at 0x100, RAM bytes 13,05,00,00 → if_done_o in cycle 5 with if_inst_o=0x00000513; ic_we_o=1, ic_waddr_o=0x100.
- Fetch with ic_hit_i=1, ic_inst_i=0xDEADBEEF during D_WR → if_done_o=1 with 0xDEADBEEF in the same cycle; RAM write sequence undisturbed.
- Simultaneous mem_req_i (load, len 01, 0x2000, RAM 0x34,0x12) and fetch miss → mem_rdata_o=0x00001234 at cycle 3; fetch refill starts after.
- Store word 0xA1B2C3D4 to 0x3000 → ram_wr_o for 4 cycles, writes D4,C3,B2,A1 at 0x3000..0x3003; mem_done_o at cycle 4.
- if_flush_i at cycle 2 of a refill → no ic_we_o, no if_done_o; IDLE at cycle 3.
- rst asserted at cycle 2 of a 4-byte store → all outputs 0 next cycle; no mem_done_o.
